// File: rtl/gpr_pkg.sv
// Shared defaults, clear-sequencer state type and address-width helper for the
// multi-port general-purpose register file.
package gpr_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_LINK_REG = 31;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    function automatic int addr_w(input int num_regs);
        return $clog2(num_regs);
    endfunction

endpackage

// File: rtl/gpr_clear_seq.sv
// Clear sequencer: sweeps cnt from 1 to NUM_REGS-1, one register zeroed per edge.
//   state | meaning
//   IDLE  | writes accepted, waiting for clear_req
//   CLEAR | sweeping, writes dropped, clr_done on the last sweep cycle
module gpr_clear_seq
    import gpr_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int AW       = addr_w(DEF_NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_req,
    output logic [AW-1:0] cnt,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          wr_ready
);

    localparam logic [AW-1:0] CNT_FIRST = AW'(1);
    localparam logic [AW-1:0] CNT_LAST  = AW'(NUM_REGS - 1);

    clr_state_t state, state_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= CNT_FIRST;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                cnt <= (cnt == CNT_LAST) ? CNT_FIRST : cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clear_req) state_nxt = CLEAR;
            CLEAR:   if (cnt == CNT_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clr_busy = (state == CLEAR);
        clr_done = (state == CLEAR) && (cnt == CNT_LAST);
        wr_ready = (state == IDLE);
    end

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-read-port register file with a registered write stage and clear sweep.
// Define GPR_BYPASS_EN to forward the write-stage data to matching read ports.
module gpr_file_mp
    import gpr_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int LINK_REG = DEF_LINK_REG,
    localparam int AW      = addr_w(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_rt,
    input  logic [AW-1:0]            wr_rd,
    input  logic                     wr_rdst,
    input  logic                     wr_link,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     clear_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              stg_vld;
    logic [AW-1:0]     stg_dest;
    logic [DATA_W-1:0] stg_data;
    logic [AW-1:0]     wr_dest;
    logic [AW-1:0]     cnt;

    gpr_clear_seq #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_clear_seq (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .cnt       (cnt),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .wr_ready  (wr_ready)
    );

    assign wr_dest = wr_link ? AW'(LINK_REG) : (wr_rdst ? wr_rd : wr_rt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg_vld  <= 1'b0;
            stg_dest <= '0;
            stg_data <= '0;
        end else begin
            stg_vld <= wr_en && wr_ready;
            if (wr_en && wr_ready) begin
                stg_dest <= wr_dest;
                stg_data <= wr_data;
            end
        end
    end

    // The sweep assignment comes last so a zeroed slot wins over a same-edge commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (stg_vld && (stg_dest != '0)) begin
                regs[stg_dest] <= stg_data;
            end
            if (clr_busy) begin
                regs[cnt] <= '0;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] arr_val;

        assign addr    = rd_addr[k*AW +: AW];
        assign arr_val = (addr == '0) ? '0 : regs[addr];
`ifdef GPR_BYPASS_EN
        assign rd_data[k*DATA_W +: DATA_W] =
            (stg_vld && (stg_dest != '0) && (stg_dest == addr)) ? stg_data : arr_val;
`else
        assign rd_data[k*DATA_W +: DATA_W] = arr_val;
`endif
    end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Self-checking bench: default-parameter instance against an array model,
// plus a 3-port/16-bit/16-register instance for back-to-back writes.
module tb_gpr_file_mp;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        wr_en = 1'b0;
    logic [4:0]  wr_rt = '0;
    logic [4:0]  wr_rd = '0;
    logic        wr_rdst = 1'b0;
    logic        wr_link = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ready;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic        clear_req = 1'b0;
    logic        clr_busy;
    logic        clr_done;

    logic        b_wr_en = 1'b0;
    logic [3:0]  b_wr_rt = '0;
    logic [3:0]  b_wr_rd = '0;
    logic        b_wr_rdst = 1'b0;
    logic        b_wr_link = 1'b0;
    logic [15:0] b_wr_data = '0;
    logic        b_wr_ready;
    logic [11:0] b_rd_addr = '0;
    logic [47:0] b_rd_data;
    logic        b_clear_req = 1'b0;
    logic        b_clr_busy;
    logic        b_clr_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpr_file_mp dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_rt(wr_rt), .wr_rd(wr_rd),
        .wr_rdst(wr_rdst), .wr_link(wr_link), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .clear_req(clear_req),
        .clr_busy(clr_busy), .clr_done(clr_done)
    );

    gpr_file_mp #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(3), .LINK_REG(15)) dut_b (
        .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_rt(b_wr_rt), .wr_rd(b_wr_rd),
        .wr_rdst(b_wr_rdst), .wr_link(b_wr_link), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .clear_req(b_clear_req),
        .clr_busy(b_clr_busy), .clr_done(b_clr_done)
    );

    // Reference model: architectural contents, one pending write, sweep cycles left.
    logic [31:0] mdl [32];
    logic        m_vld;
    logic [4:0]  m_dest;
    logic [31:0] m_data;
    int          m_left;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) mdl[i] = '0;
            m_vld = 1'b0;
            m_dest = '0;
            m_data = '0;
            m_left = 0;
        end else begin
            logic cap;
            if (m_vld && m_dest != 0) mdl[m_dest] = m_data;
            cap = wr_en && (m_left == 0);
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) for (int i = 0; i < 32; i++) mdl[i] = '0;
            end else if (clear_req) begin
                m_left = 31;
            end
            m_vld = cap;
            if (cap) begin
                m_dest = wr_link ? 5'd31 : (wr_rdst ? wr_rd : wr_rt);
                m_data = wr_data;
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return '0;
`ifdef GPR_BYPASS_EN
        if (m_vld && m_dest == a) return m_data;
`endif
        return mdl[a];
    endfunction

    task automatic set_wr(input logic en, input logic [4:0] rt, input logic [4:0] rd,
                          input logic rdst, input logic link, input logic [31:0] data);
        wr_en = en; wr_rt = rt; wr_rd = rd; wr_rdst = rdst; wr_link = link; wr_data = data;
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            set_wr(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
                   ($urandom_range(0, 7) == 0), $urandom);
            rd_addr[4:0] = ($urandom_range(0, 1) == 1) ? m_dest : 5'($urandom);
            rd_addr[9:5] = 5'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rd_data[k*32 +: 32] !== exp_rd(rd_addr[k*5 +: 5])) begin
                    errors++;
                    $display("FAIL random_read port%0d addr %0d: got %h expected %h", k,
                             rd_addr[k*5 +: 5], rd_data[k*32 +: 32], exp_rd(rd_addr[k*5 +: 5]));
                end
            end
            checks++;
            if (wr_ready !== 1'b1 || clr_busy !== 1'b0 || clr_done !== 1'b0) begin
                errors++;
                $display("FAIL random_status: got ready=%b busy=%b done=%b expected 1 0 0",
                         wr_ready, clr_busy, clr_done);
            end
        end
        @(negedge clk);
        set_wr(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        test_random(20);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (wr_ready !== 1'b1 || clr_busy !== 1'b0 || clr_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got ready=%b busy=%b done=%b expected 1 0 0",
                     wr_ready, clr_busy, clr_done);
        end
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            checks++;
            if (rd_data !== 64'h0) begin
                errors++;
                $display("FAIL reset_read addr %0d: got %h expected 0", a, rd_data);
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_write_latency();
        logic [31:0] old5;
        old5 = mdl[5];
        @(negedge clk);
        set_wr(1, 5'd9, 5'd5, 1, 0, 32'hDEADBEEF);
        rd_addr = {5'd9, 5'd5};
        @(negedge clk);
        set_wr(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
`ifdef GPR_BYPASS_EN
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL latency_1: got %h expected %h", rd_data[31:0], 32'hDEADBEEF);
        end
`else
        if (rd_data[31:0] !== old5) begin
            errors++;
            $display("FAIL latency_1: got %h expected %h", rd_data[31:0], old5);
        end
`endif
        @(negedge clk);
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL latency_2: got %h expected %h", rd_data[31:0], 32'hDEADBEEF);
        end
        checks++;
        if (rd_data[63:32] !== exp_rd(5'd9)) begin
            errors++;
            $display("FAIL latency_rt_untouched: got %h expected %h", rd_data[63:32], exp_rd(5'd9));
        end
    endtask

    task automatic test_link();
        logic [31:0] old3;
        old3 = mdl[3];
        @(negedge clk);
        set_wr(1, 5'd7, 5'd3, 1, 1, 32'h40);
        @(negedge clk);
        set_wr(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rd_addr = {5'd31, 5'd3};
        #1;
        checks++;
        if (rd_data[63:32] !== 32'h40) begin
            errors++;
            $display("FAIL link_r31: got %h expected %h", rd_data[63:32], 32'h40);
        end
        checks++;
        if (rd_data[31:0] !== old3) begin
            errors++;
            $display("FAIL link_r3: got %h expected %h", rd_data[31:0], old3);
        end
    endtask

    task automatic test_reg0();
        @(negedge clk);
        set_wr(1, 5'd0, 5'd12, 0, 0, 32'hFFFFFFFF);
        rd_addr = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_wr(0, 0, 0, 0, 0, 0);
            #1;
            checks++;
            if (rd_data !== 64'h0) begin
                errors++;
                $display("FAIL reg0_read cycle %0d: got %h expected 0", i, rd_data);
            end
        end
    endtask

    task automatic test_clear();
        int busy_cnt;
        int done_cnt;
        int done_at;
        bit finished;
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            set_wr(1, 5'd0, 5'(i), 1, 0, 32'(i));
        end
        @(negedge clk);
        set_wr(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        clear_req = 1'b1;
        rd_addr = {5'd31, 5'd1};
        busy_cnt = 0; done_cnt = 0; done_at = -1; finished = 0;
        for (int c = 0; c < 100 && !finished; c++) begin
            @(negedge clk);
            clear_req = (busy_cnt == 9);
            set_wr(1, 5'd0, 5'd20, 1, 0, 32'hABCD);
            #1;
            if (!clr_busy) begin
                finished = 1;
            end else begin
                busy_cnt++;
                if (clr_done) begin
                    done_cnt++;
                    done_at = busy_cnt;
                end
                checks++;
                if (rd_data[63:32] !== 32'd31 || rd_data[31:0] !== (busy_cnt == 1 ? 32'd1 : 32'd0)) begin
                    errors++;
                    $display("FAIL clear_partial cycle %0d: got r31=%h r1=%h expected 1f %0d", busy_cnt,
                             rd_data[63:32], rd_data[31:0], busy_cnt == 1);
                end
                checks++;
                if (wr_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_ready cycle %0d: got %b expected 0", busy_cnt, wr_ready);
                end
            end
        end
        set_wr(0, 0, 0, 0, 0, 0);
        clear_req = 1'b0;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL clear_timeout: got busy after 100 cycles expected idle");
        end
        checks++;
        if (busy_cnt != 31) begin
            errors++;
            $display("FAIL clear_busy_len: got %0d expected 31", busy_cnt);
        end
        checks++;
        if (done_cnt != 1 || done_at != 31) begin
            errors++;
            $display("FAIL clear_done: got %0d pulses at %0d expected 1 at 31", done_cnt, done_at);
        end
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            checks++;
            if (rd_data !== {exp_rd(5'(31 - a)), exp_rd(5'(a))} || rd_data !== 64'h0) begin
                errors++;
                $display("FAIL clear_contents addr %0d: got %h expected 0", a, rd_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va, vb, vc;
        va = 16'($urandom); vb = 16'($urandom); vc = 16'($urandom);
        @(negedge clk);
        b_wr_en = 1; b_wr_rdst = 1; b_wr_rd = 4'd7; b_wr_data = va;
        @(negedge clk);
        b_wr_data = vb;
        @(negedge clk);
        b_wr_rd = 4'd8; b_wr_data = vc;
        @(negedge clk);
        b_wr_en = 0;
        @(negedge clk);
        @(negedge clk);
        b_rd_addr = {4'd0, 4'd8, 4'd7};
        #1;
        checks++;
        if (b_rd_data !== {16'h0, vc, vb}) begin
            errors++;
            $display("FAIL back_to_back: got %h expected %h", b_rd_data, {16'h0, vc, vb});
        end
        checks++;
        if (b_wr_ready !== 1'b1 || b_clr_busy !== 1'b0 || b_clr_done !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_status: got %b%b%b expected 100", b_wr_ready, b_clr_busy, b_clr_done);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_write_latency();
        test_link();
        test_reg0();
        test_random(300);
        test_clear();
        test_random(100);
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
